// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int unsigned LINE_W   = 128;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned WORDS    = LINE_W / WORD_W;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate
  } dcache_state_e;

  function automatic int unsigned tag_w(input int unsigned index_w);
    return 32 - index_w - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous word-merge write,
// valid and dirty bits cleared by the synchronous reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 5,
  parameter int unsigned TAG_W   = tag_w(INDEX_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] idx_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [LINE_W-1:0]  line_o,
  input  logic               we_i,
  input  logic [WORDS-1:0]   word_en_i,
  input  logic [LINE_W-1:0]  wdata_i,
  input  logic               tag_we_i,
  input  logic [TAG_W-1:0]   tag_i,
  input  logic               dirty_set_i,
  input  logic               dirty_clr_i
);

  localparam int unsigned Lines = 2 ** INDEX_W;

  logic [TAG_W-1:0]  tag_q  [Lines];
  logic [LINE_W-1:0] data_q [Lines];
  logic [Lines-1:0]  valid_q;
  logic [Lines-1:0]  dirty_q;
  logic [LINE_W-1:0] merged;

  assign tag_o   = tag_q[idx_i];
  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_comb begin
    merged = data_q[idx_i];
    for (int w = 0; w < WORDS; w++) begin
      if (word_en_i[w]) merged[w*WORD_W +: WORD_W] = wdata_i[w*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i)     data_q[idx_i] <= merged;
    if (tag_we_i) tag_q[idx_i]  <= tag_i;
  end

  // A tag write always installs a fresh line, so it also marks the line valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (tag_we_i) valid_q[idx_i] <= 1'b1;
      if (dirty_clr_i)      dirty_q[idx_i] <= 1'b0;
      else if (dirty_set_i) dirty_q[idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate D-cache controller for the MEM stage.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p1_req_i,
  input  logic              p1_wr_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned TAG_W = tag_w(INDEX_W);

  dcache_state_e state_q, state_d;

  logic [TAG_W-1:0]   req_tag, rd_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_word;
  logic               rd_valid, rd_dirty, hit;
  logic [LINE_W-1:0]  rd_line;
  logic               we, tag_we, dirty_set, dirty_clr;
  logic [WORDS-1:0]   word_en;
  logic [LINE_W-1:0]  wdata;
  logic               unused_addr;

  assign req_tag     = p1_addr_i[31 -: TAG_W];
  assign req_idx     = p1_addr_i[OFFSET_W +: INDEX_W];
  assign req_word    = p1_addr_i[3:2];
  assign unused_addr = ^p1_addr_i[1:0];

  dcache_sram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (req_idx),
    .tag_o       (rd_tag),
    .valid_o     (rd_valid),
    .dirty_o     (rd_dirty),
    .line_o      (rd_line),
    .we_i        (we),
    .word_en_i   (word_en),
    .wdata_i     (wdata),
    .tag_we_i    (tag_we),
    .tag_i       (req_tag),
    .dirty_set_i (dirty_set),
    .dirty_clr_i (dirty_clr)
  );

  assign hit        = rd_valid & (rd_tag == req_tag);
  assign p1_stall_o = (state_q != StIdle) | (p1_req_i & ~hit);
  assign p1_data_o  = (p1_req_i & hit) ? rd_line[{req_word, 5'b0} +: WORD_W] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // mem_* are decoded from the state and the held request, so they stay stable
  // for the whole transaction.
  always_comb begin
    state_d      = state_q;
    we           = 1'b0;
    word_en      = '0;
    wdata        = '0;
    tag_we       = 1'b0;
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    unique case (state_q)
      StIdle: begin
        if (p1_req_i) begin
          if (hit) begin
            if (p1_wr_i) begin
              we        = 1'b1;
              word_en   = 4'b0001 << req_word;
              wdata     = {WORDS{p1_data_i}};
              dirty_set = 1'b1;
            end
          end else if (rd_valid & rd_dirty) begin
            state_d = StWriteback;
          end else begin
            state_d = StAllocate;
          end
        end
      end
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, req_idx, 4'b0};
        mem_data_o   = rd_line;
        if (mem_ack_i) begin
          dirty_clr = 1'b1;
          state_d   = StAllocate;
        end
      end
      StAllocate: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, 4'b0};
        if (mem_ack_i) begin
          we        = 1'b1;
          word_en   = '1;
          wdata     = mem_data_i;
          tag_we    = 1'b1;
          dirty_clr = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic refill_q;
  logic hit_inc, miss_inc;

  // The retry cycle right after a refill is the completion of the miss, not a hit.
  assign hit_inc  = (state_q == StIdle) & p1_req_i & hit & ~refill_q;
  assign miss_inc = (state_q == StIdle) & p1_req_i & ~hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      refill_q <= (state_q == StAllocate) & mem_ack_i;
      if (hit_inc && hit_cnt_o != 32'hFFFF_FFFF)   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_inc && miss_cnt_o != 32'hFFFF_FFFF) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
